// File: rtl/multi_delay_timer_pkg.sv
// Shared types and constants for the multi-channel delay timer.
package timer_pkg;

    // Per-channel FSM state.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_e;

    // 1 ms base tick from a 1 MHz clock.
    localparam int CLK_PER_TICK_1MHZ_MS = 32'd1000;
    // 10 base ticks per delay unit: 1/100 s.
    localparam int UNITS_PER_CENTISEC   = 32'd10;

    // Smallest counter width able to hold the largest loaded count,
    // (2^delay_w - 1) * units.
    function automatic int min_cnt_w(input int delay_w, input int units);
        longint max_count;
        int     width;
        max_count = ((64'sd1 <<< delay_w) - 64'sd1) * longint'(units);
        width     = $clog2(max_count + 64'sd1);
        if (width < 32'sd1) begin
            width = 32'sd1;
        end else begin
            width = width;
        end
        return width;
    endfunction

endpackage

// File: rtl/multi_delay_timer_if.sv
// Control/status bundle of the delay-timer bank. The master side drives the
// requests; the timer bank is the slave.
interface multi_delay_timer_if #(
    parameter int NUM_CH  = 4,
    parameter int DELAY_W = 8,
    parameter int CNT_W   = 12
);
    logic                        enable;
    logic [NUM_CH-1:0]           start;
    logic [NUM_CH-1:0]           cancel;
    logic [NUM_CH-1:0]           periodic;
    logic [NUM_CH*DELAY_W-1:0]   delay;
    logic [NUM_CH-1:0]           busy;
    logic [NUM_CH-1:0]           done;
    logic [NUM_CH*CNT_W-1:0]     remaining;

    modport master (
        output enable, start, cancel, periodic, delay,
        input  busy, done, remaining
    );

    modport slave (
        input  enable, start, cancel, periodic, delay,
        output busy, done, remaining
    );
endinterface

// File: rtl/multi_delay_timer_channel.sv
// One down-counting delay channel: load on start, count base ticks,
// pulse done on expiry, optionally auto-reload.
module timer_channel
    import timer_pkg::*;
#(
    parameter int DELAY_W         = 8,
    parameter int CNT_W           = 12,
    parameter int UNITS_PER_DELAY = UNITS_PER_CENTISEC
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               cancel,
    input  logic               periodic,
    input  logic [DELAY_W-1:0] delay,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   remaining
);

    localparam logic [CNT_W-1:0] UNITS_C = CNT_W'(UNITS_PER_DELAY);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(32'd1);

    chan_state_e        state_r, state_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic [CNT_W-1:0]   reload_r, reload_s;
    logic               periodic_r, periodic_s;
    logic               done_r, done_s;
    logic [CNT_W-1:0]   load_s;
    logic               busy_s;
    logic [CNT_W-1:0]   remaining_s;

    // State register: FSM state, count, reload value, mode and done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            count_r    <= ZERO_C;
            reload_r   <= ZERO_C;
            periodic_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            count_r    <= count_s;
            reload_r   <= reload_s;
            periodic_r <= periodic_s;
            done_r     <= done_s;
        end
    end

    // Next state: cancel beats start beats tick; a zero-length load expires at once.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        reload_s   = reload_r;
        periodic_s = periodic_r;
        done_s     = 1'b0;
        // Widen before multiplying so the product is never truncated.
        load_s     = CNT_W'(delay) * UNITS_C;
        if (cancel) begin
            state_s = ST_IDLE;
            count_s = ZERO_C;
        end else if (start) begin
            count_s    = load_s;
            reload_s   = load_s;
            periodic_s = periodic;
            if (load_s != ZERO_C) begin
                state_s = ST_RUN;
            end else begin
                state_s = ST_IDLE;
                done_s  = 1'b1;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_RUN: begin
                    if (tick) begin
                        if (count_r > ONE_C) begin
                            count_s = count_r - ONE_C;
                        end else begin
                            done_s = 1'b1;
                            if (periodic_r) begin
                                // Reload on the expiring tick so no tick is lost.
                                count_s = reload_r;
                            end else begin
                                count_s = ZERO_C;
                                state_s = ST_IDLE;
                            end
                        end
                    end else begin
                        count_s = count_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    count_s = ZERO_C;
                end
            endcase
        end
    end

    // Outputs: busy from the state register, remaining forced to zero outside RUN.
    always_comb begin
        busy_s = (state_r == ST_RUN);
        if (state_r == ST_RUN) begin
            remaining_s = count_r;
        end else begin
            remaining_s = ZERO_C;
        end
    end

    assign busy      = busy_s;
    assign done      = done_r;
    assign remaining = remaining_s;

endmodule

// File: rtl/multi_delay_timer.sv
// Bank of independent delay timers sharing one free-running tick prescaler.
module multi_delay_timer
    import timer_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DELAY_W         = 8,
    parameter int CLK_PER_TICK    = CLK_PER_TICK_1MHZ_MS,
    parameter int UNITS_PER_DELAY = UNITS_PER_CENTISEC,
    parameter int CNT_W           = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    multi_delay_timer_if.slave   bus
);

    localparam int               PRE_W      = (CLK_PER_TICK > 32'sd1) ? $clog2(CLK_PER_TICK) : 32'sd1;
    localparam logic [PRE_W-1:0] PRE_LAST_C = PRE_W'(CLK_PER_TICK - 32'sd1);
    localparam logic [PRE_W-1:0] PRE_ZERO_C = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0] PRE_ONE_C  = PRE_W'(32'd1);

    logic [PRE_W-1:0]        presc_r, presc_s;
    logic                    tick_s;
    logic [NUM_CH-1:0]       busy_vec_s;
    logic [NUM_CH-1:0]       done_vec_s;
    logic [NUM_CH*CNT_W-1:0] remaining_vec_s;

    // Prescaler register; its phase is never disturbed by channel starts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_r <= PRE_ZERO_C;
        end else begin
            presc_r <= presc_s;
        end
    end

    // Prescaler next value and the shared base tick; everything freezes while disabled.
    always_comb begin
        tick_s = bus.enable && (presc_r == PRE_LAST_C);
        if (!bus.enable) begin
            presc_s = presc_r;
        end else if (tick_s) begin
            presc_s = PRE_ZERO_C;
        end else begin
            presc_s = presc_r + PRE_ONE_C;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(
            .DELAY_W         (DELAY_W),
            .CNT_W           (CNT_W),
            .UNITS_PER_DELAY (UNITS_PER_DELAY)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .tick      (tick_s),
            .start     (bus.start[i]),
            .cancel    (bus.cancel[i]),
            .periodic  (bus.periodic[i]),
            .delay     (bus.delay[i*DELAY_W +: DELAY_W]),
            .busy      (busy_vec_s[i]),
            .done      (done_vec_s[i]),
            .remaining (remaining_vec_s[i*CNT_W +: CNT_W])
        );
    end

    assign bus.busy      = busy_vec_s;
    assign bus.done      = done_vec_s;
    assign bus.remaining = remaining_vec_s;

endmodule

// File: tb/tb_multi_delay_timer.sv
// Directed and randomized checks of multi_delay_timer against a
// tick-level behavioural model of the timer bank.
module tb_multi_delay_timer;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int CW  = 12;
    localparam int CPT = 4;
    localparam int UPD = 2;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    // Model state: enabled-cycle phase and per-channel tick counts.
    int m_phase;
    int m_cnt  [NCH];
    int m_rel  [NCH];
    bit m_run  [NCH];
    bit m_per  [NCH];
    bit m_done [NCH];

    multi_delay_timer_if #(.NUM_CH(NCH), .DELAY_W(DW), .CNT_W(CW)) bus ();

    multi_delay_timer #(
        .NUM_CH(NCH), .DELAY_W(DW), .CLK_PER_TICK(CPT),
        .UNITS_PER_DELAY(UPD), .CNT_W(CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic void model_clear();
        m_phase = 0;
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_rel[c] = 0; m_run[c] = 1'b0;
            m_per[c] = 1'b0; m_done[c] = 1'b0;
        end
    endfunction

    // Apply one clock edge of the specified behaviour to the model.
    function automatic void model_edge();
        bit tick;
        int n;
        if (reset) begin
            model_clear();
            return;
        end
        tick = bus.enable && (m_phase == CPT - 1);
        if (bus.enable) m_phase = (m_phase + 1) % CPT;
        for (int c = 0; c < NCH; c++) begin
            m_done[c] = 1'b0;
            if (bus.cancel[c]) begin
                m_run[c] = 1'b0; m_cnt[c] = 0;
            end else if (bus.start[c]) begin
                n = int'(bus.delay[c*DW +: DW]) * UPD;
                m_rel[c] = n; m_per[c] = bus.periodic[c];
                m_cnt[c] = n; m_run[c] = (n != 0);
                if (n == 0) m_done[c] = 1'b1;
            end else if (m_run[c] && tick) begin
                if (m_cnt[c] == 1) begin
                    m_done[c] = 1'b1;
                    if (m_per[c]) m_cnt[c] = m_rel[c];
                    else begin m_cnt[c] = 0; m_run[c] = 1'b0; end
                end else begin
                    m_cnt[c] = m_cnt[c] - 1;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [NCH-1:0]    eb, ed;
        logic [NCH*CW-1:0] er;
        for (int c = 0; c < NCH; c++) begin
            eb[c] = m_run[c];
            ed[c] = m_done[c];
            er[c*CW +: CW] = CW'(m_cnt[c]);
        end
        check("busy", 64'(bus.busy), 64'(eb));
        check("done", 64'(bus.done), 64'(ed));
        check("remaining", 64'(bus.remaining), 64'(er));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic start_ch(input int c, input int d, input bit per);
        bus.start[c] = 1'b1;
        bus.delay[c*DW +: DW] = DW'(d);
        bus.periodic[c] = per;
        step();
        bus.start[c] = 1'b0;
    endtask

    initial begin
        int first, npulse, en_cycles, busy_bad;
        int times[$];
        bit found;
        logic [CW-1:0] frozen;
        logic [NCH-1:0] dvec;

        reset = 1'b1;
        bus.enable = 1'b0; bus.start = '0; bus.cancel = '0;
        bus.periodic = '0; bus.delay = '0;
        model_clear();
        repeat (2) step();
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_rem", 64'(bus.remaining), 64'd0);
        reset = 1'b0;
        bus.enable = 1'b1;
        step();

        // One-shot ch0, delay 3 -> 6 ticks, done 21..24 cycles after start.
        start_ch(0, 3, 1'b0);
        check("t1_busy0", 64'(bus.busy[0]), 64'd1);
        check("t1_rem0", 64'(bus.remaining[0 +: CW]), 64'd6);
        first = -1; npulse = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus.done[0]) begin npulse++; if (first < 0) first = k; end
        end
        check("t1_window", 64'(first >= 21 && first <= 24), 64'd1);
        check("t1_npulse", 64'(npulse), 64'd1);
        check("t1_idle0", 64'(bus.busy[0]), 64'd0);

        // Periodic ch1, delay 1 -> done every 8 cycles.
        start_ch(1, 1, 1'b1);
        busy_bad = 0;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (bus.done[1]) times.push_back(k);
            if (bus.busy[1] !== 1'b1) busy_bad++;
        end
        check("t2_busy_hold", 64'(busy_bad), 64'd0);
        check("t2_npulse_ge6", 64'(times.size() >= 6), 64'd1);
        if (times.size() >= 6) begin
            for (int i = 1; i <= 5; i++) check("t2_period", 64'(times[i] - times[i-1]), 64'd8);
        end
        bus.cancel[1] = 1'b1; step(); bus.cancel[1] = 1'b0;
        check("t2_cancel1", 64'(bus.busy[1]), 64'd0);

        // Zero delay on ch2 (periodic requested): immediate done, never busy.
        start_ch(2, 0, 1'b1);
        check("t3_done2", 64'(bus.done[2]), 64'd1);
        check("t3_busy2", 64'(bus.busy[2]), 64'd0);
        busy_bad = 0; npulse = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.busy[2]) busy_bad++;
            if (bus.done[2]) npulse++;
        end
        check("t3_never_busy", 64'(busy_bad), 64'd0);
        check("t3_single_done", 64'(npulse), 64'd0);

        // Cancel ch0 at remaining 3, then start+cancel in the same cycle.
        for (int rep = 0; rep < 2; rep++) begin
            start_ch(0, 3, 1'b0);
            found = 1'b0;
            for (int k = 0; k < 30 && !found; k++) begin
                step();
                if (bus.remaining[0 +: CW] == CW'(3)) found = 1'b1;
            end
            check("t4_reach3", 64'(found), 64'd1);
            bus.cancel[0] = 1'b1;
            if (rep == 1) bus.start[0] = 1'b1;
            step();
            bus.cancel[0] = 1'b0; bus.start[0] = 1'b0;
            check("t4_idle", 64'(bus.busy[0]), 64'd0);
            check("t4_rem0", 64'(bus.remaining[0 +: CW]), 64'd0);
            npulse = 0;
            for (int k = 0; k < 30; k++) begin
                step();
                if (bus.done[0]) npulse++;
            end
            check("t4_no_done", 64'(npulse), 64'd0);
        end

        // ch3 delay 4 with enable dropped for 20 cycles: 29..32 enabled cycles.
        start_ch(3, 4, 1'b0);
        en_cycles = 0; found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(); en_cycles++;
            if (bus.done[3]) found = 1'b1;
        end
        frozen = bus.remaining[3*CW +: CW];
        bus.enable = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            check("t5_frozen", 64'(bus.remaining[3*CW +: CW]), 64'(frozen));
        end
        bus.enable = 1'b1;
        for (int k = 0; k < 40 && !found; k++) begin
            step(); en_cycles++;
            if (bus.done[3]) found = 1'b1;
        end
        check("t5_found", 64'(found), 64'd1);
        check("t5_window", 64'(en_cycles >= 29 && en_cycles <= 32), 64'd1);

        // All channels together: done bits pulse in the same cycle.
        for (int c = 0; c < NCH; c++) bus.delay[c*DW +: DW] = DW'(2);
        bus.periodic = '0; bus.start = '1;
        step();
        bus.start = '0;
        dvec = '0;
        for (int k = 0; k < 30 && dvec == '0; k++) begin
            step();
            dvec = bus.done;
        end
        check("t6_all_done", 64'(dvec), 64'hF);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            bus.enable = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < NCH; c++) begin
                bus.start[c]    = ($urandom_range(0, 15) == 0);
                bus.cancel[c]   = ($urandom_range(0, 39) == 0);
                bus.periodic[c] = $urandom_range(0, 1) != 0;
                bus.delay[c*DW +: DW] = DW'($urandom_range(0, 5));
            end
            step();
        end
        bus.start = '0; bus.cancel = '0; bus.enable = 1'b1;

        // Asynchronous reset mid-run.
        for (int c = 0; c < NCH; c++) bus.delay[c*DW +: DW] = DW'(3);
        bus.periodic = 4'b0101; bus.start = '1;
        step();
        bus.start = '0;
        repeat (5) step();
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check("t7_async_busy", 64'(bus.busy), 64'd0);
        check("t7_async_done", 64'(bus.done), 64'd0);
        check("t7_async_rem", 64'(bus.remaining), 64'd0);
        repeat (3) step();
        reset = 1'b0;
        npulse = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (bus.done != '0) npulse++;
        end
        check("t7_no_done", 64'(npulse), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_delay_timer.md
Name: multi_delay_timer

Overview:
- Bank of NUM_CH independent down-counting delay timers sharing one clock prescaler.
- Each channel counts a requested delay in coarse units (default 1/100 s) and pulses done on expiry.
- Supports one-shot and periodic (auto-reload) modes, per-channel cancel, and a live remaining-count readback.
- Sits beside the sequencer/PC logic as its general-purpose timing resource; supersedes the single-channel delay counter.

Parameters:
- NUM_CH, 4, number of independent timer channels (1..16).
- DELAY_W, 8, width of each requested delay value.
- CLK_PER_TICK, 1000, clock cycles per base tick (1 ms at 1 MHz); must be >= 2.
- UNITS_PER_DELAY, 10, base ticks per delay unit (10 ms = 1/100 s).
- CNT_W, 12, per-channel down-counter width; must hold (2^DELAY_W - 1) * UNITS_PER_DELAY.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  global run enable; low freezes the prescaler and all channel counts.
- start  in  NUM_CH  per-channel load/start strobe, one cycle.
- cancel  in  NUM_CH  per-channel abort strobe.
- periodic  in  NUM_CH  mode sampled at start: 1 = auto-reload, 0 = one-shot.
- delay  in  NUM_CH*DELAY_W  packed delays; channel i uses bits [i*DELAY_W +: DELAY_W].
- busy  out  NUM_CH  channel is in the RUN state.
- done  out  NUM_CH  one-cycle expiry pulse per channel.
- remaining  out  NUM_CH*CNT_W  packed live down-count per channel, in base ticks.

Behaviour:
- Reset (async, reset=1):
  - prescaler = 0, all channels IDLE, counts = 0, stored reload = 0, mode = one-shot.
  - busy = 0, done = 0, remaining = 0.
  - Asserting reset mid-count aborts immediately with no done pulse.
- Prescaler:
  - Counts 0..CLK_PER_TICK-1 while enable = 1 and wraps to 0.
  - Internal tick is high in the cycle where prescaler = CLK_PER_TICK-1 and enable = 1.
  - Holds its value while enable = 0.
  - Never reset by start; first-tick phase is free-running.
  - Expiry therefore occurs between (N-1)*CLK_PER_TICK+1 and N*CLK_PER_TICK enabled cycles after start, where N = delay*UNITS_PER_DELAY.
- Channel FSM, two states:
  - IDLE: busy = 0.
  - RUN: busy = 1.
- Load on start (any state):
  - Load count = delay*UNITS_PER_DELAY, computed at full CNT_W width with no truncation.
  - Store that value as the reload value and latch periodic.
  - If the loaded value is nonzero, go to RUN.
  - If the loaded value is 0, stay or return to IDLE and pulse done on the next edge; periodic is ignored for a zero delay.
- start while RUN restarts the channel with the new delay and suppresses any expiry in that cycle.
- RUN on tick:
  - count > 1: count decrements by 1.
  - count = 1: done pulses on that edge (done is registered, high for exactly one cycle).
    - Periodic: count reloads with no lost tick.
    - One-shot: count = 0, go to IDLE.
- cancel:
  - Forces IDLE with count = 0 and no done pulse.
  - Priority: reset > cancel > start > tick.
  - cancel and start in the same cycle: the channel ends IDLE.
- enable = 0: no ticks occur, but start and cancel are still honoured.
- Channels are fully independent; simultaneous expiries on several channels pulse their done bits in the same cycle.
- remaining mirrors each channel count combinationally from its register; zero in IDLE.

Decomposition:
- Shared package timer_pkg holds:
  - the FSM state enum (ST_IDLE, ST_RUN);
  - default constants CLK_PER_TICK_1MHZ_MS = 1000 and UNITS_PER_CENTISEC = 10;
  - a function computing the minimum CNT_W.
- One natural sub-module, timer_channel: owns the FSM, count, reload value, mode, busy and done for one channel.
- Top level holds the prescaler and a generate loop instantiating NUM_CH timer_channel instances.

Test Plan (bench uses CLK_PER_TICK=4, UNITS_PER_DELAY=2, NUM_CH=4):
- Reset, enable=1, ch0 start with delay=3, one-shot:
  - busy0 rises the next cycle and remaining0 = 6.
  - done0 pulses once after 6 ticks (21..24 cycles after start); then busy0 = 0 and remaining0 = 0.
- ch1 delay=1, periodic:
  - done1 pulses every 8 cycles exactly, over 5 periods.
  - busy1 stays 1 throughout and remaining1 cycles 2, 1, 2, ...
- ch2 delay=0:
  - done2 pulses one cycle after start; busy2 never rises, even with periodic=1.
- ch0 running at remaining0 = 3:
  - Assert cancel0: ch0 goes IDLE next edge and no done0 ever pulses.
  - Repeat with start0 and cancel0 in the same cycle: ch0 ends IDLE.
- ch3 delay=4:
  - Drop enable for 20 cycles mid-count: remaining3 is frozen for those cycles.
  - Total enabled cycles to done3 is 29..32.
- All four channels started with delay=2 in the same cycle: four done bits pulse in the same cycle.
- Assert reset mid-run: all outputs read 0 immediately (asynchronous), with no done pulses.
